// File: rtl/ldpc_bf_decoder.sv
// Hard-decision bit-flipping LDPC decoder: syndrome check, majority-vote flip of the
// most-implicated bits, repeat until the syndrome clears or the iteration budget is spent.
module ldpc_bf_decoder #(
    parameter int N        = 11,
    parameter int K        = 6,
    parameter int M        = N - K,
    parameter int MAX_ITER = 8,
    parameter logic [M*N-1:0] H_MATRIX = {11'h430, 11'h20E, 11'h12D, 11'h09B, 11'h077}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] rx_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] corrected,
    output logic [K-1:0] decoded,
    output logic         success,
    output logic [7:0]   iter_count
);

    localparam int UW = $clog2(M + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYND,
        S_FLIP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_corrected;
    logic [M-1:0]  r_synd;
    logic [7:0]    r_iter;
    logic          r_success;
    logic          r_out_valid;

    logic [M-1:0]  w_synd;
    logic [UW-1:0] w_votes [N];
    logic [UW-1:0] w_umax;
    logic [N-1:0]  w_flip_mask;
    logic          w_synd_zero;
    logic          w_iter_max;

    function automatic logic parity_row(input logic [N-1:0] row, input logic [N-1:0] word);
        return ^(row & word);
    endfunction

    always_comb begin
        for (int r = 0; r < M; r++) begin
            w_synd[r] = parity_row(H_MATRIX[r*N +: N], r_corrected);
        end
    end

    // Each bit collects one vote per unsatisfied check it participates in.
    always_comb begin
        w_umax = '0;
        for (int j = 0; j < N; j++) begin
            w_votes[j] = '0;
            for (int r = 0; r < M; r++) begin
                w_votes[j] = w_votes[j] + UW'(H_MATRIX[r*N + j] & r_synd[r]);
            end
            if (w_votes[j] > w_umax) begin
                w_umax = w_votes[j];
            end
        end
        for (int j = 0; j < N; j++) begin
            w_flip_mask[j] = (w_votes[j] == w_umax) && (w_umax != '0);
        end
    end

    assign w_synd_zero = (r_synd == '0);
    assign w_iter_max  = (r_iter == 8'(MAX_ITER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_SYND;
            S_SYND: w_next = S_FLIP;
            S_FLIP: begin
                if (w_synd_zero || w_iter_max) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SYND;
                end
            end
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, syndrome on SYND, decide or flip on FLIP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corrected <= '0;
            r_synd      <= '0;
            r_iter      <= '0;
            r_success   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_corrected <= rx_word;
                        r_iter      <= '0;
                        r_success   <= 1'b0;
                    end
                end
                S_SYND: begin
                    r_synd <= w_synd;
                end
                S_FLIP: begin
                    if (w_synd_zero) begin
                        r_success   <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else if (w_iter_max) begin
                        r_success   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_corrected <= r_corrected ^ w_flip_mask;
                        r_iter      <= r_iter + 8'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign corrected  = r_corrected;
    assign decoded    = r_corrected[K-1:0];
    assign success    = r_success;
    assign iter_count = r_iter;

endmodule
